mem_port_arbiter: RTL

Shares one single-ported memory between the core's instruction-fetch and data-access requesters. Sits between `discrete_core`-style imem/dmem request ports and a unified memory with a req/gnt/rvalid handshake. Keeps one transaction outstanding at a time, prioritises data over fetch, and returns each requester a registered response with a one-cycle ack pulse.

---
 rtl/mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between an instruction-fetch
//            requester (imem) and a data-access requester (dmem). One
//            downstream transaction is in flight at a time, data beats fetch
//            when both ask, and each requester gets a registered read-data
//            word plus a one-cycle ack pulse on completion.
//
// Ports    : clock, reset           - rising-edge clock, synchronous
//                                     active-high reset
//            i_imem_* / o_imem_*    - fetch port (req/addr in, rdata/ack out)
//            i_dmem_* / o_dmem_*    - data port (req/we/wmask/addr/wdata in,
//                                     rdata/ack out)
//            o_mem_*                - registered downstream request
//            i_mem_gnt              - downstream accepted the request
//            i_mem_rvalid/i_mem_rdata - downstream completion and read data
//
// Options  : MEM_ARB_FAIRNESS_EN - when defined, after MAX_DATA_BURST
//            consecutive data grants issued while fetch was also waiting,
//            the next contested grant goes to fetch. When undefined, data
//            has strict priority and fetch may starve.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                clock,
    input  logic                reset,

    // Instruction-fetch requester
    input  logic                i_imem_req,
    input  logic [ADDR_W-1:0]   i_imem_addr,
    output logic [DATA_W-1:0]   o_imem_rdata,
    output logic                o_imem_ack,

    // Data-access requester
    input  logic                i_dmem_req,
    input  logic                i_dmem_we,
    input  logic [DATA_W/8-1:0] i_dmem_wmask,
    input  logic [ADDR_W-1:0]   i_dmem_addr,
    input  logic [DATA_W-1:0]   i_dmem_wdata,
    output logic [DATA_W-1:0]   o_dmem_rdata,
    output logic                o_dmem_ack,

    // Unified downstream memory
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int c_MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a requester
        S_REQ  = 2'd1,   // request presented downstream, waiting for gnt
        S_WAIT = 2'd2,   // request accepted, waiting for rvalid
        S_RESP = 2'd3    // ack pulse to the owner
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Downstream request registers
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [c_MASK_W-1:0]   r_mem_wmask, w_mem_wmask_nxt;
    logic [ADDR_W-1:0]     r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;

    // Owner of the in-flight transaction: 1 = dmem, 0 = imem
    logic                  r_owner_d,   w_owner_d_nxt;

    // Per-requester response registers
    logic [DATA_W-1:0]     r_imem_rdata, w_imem_rdata_nxt;
    logic [DATA_W-1:0]     r_dmem_rdata, w_dmem_rdata_nxt;
    logic                  r_imem_ack,   w_imem_ack_nxt;
    logic                  r_dmem_ack,   w_dmem_ack_nxt;

    // Arbitration decision
    logic                  w_any_req;
    logic                  w_force_imem;
    logic                  w_pick_d;

    assign w_any_req = i_imem_req | i_dmem_req;
    // Data wins whenever it asks, unless the fairness limit hands this
    // contested slot to fetch.
    assign w_pick_d  = i_dmem_req & ~(i_imem_req & w_force_imem);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int c_CNT_W = $clog2(MAX_DATA_BURST + 1);

    logic [c_CNT_W-1:0]    r_burst_cnt, w_burst_cnt_nxt;
    logic                  w_grant;

    assign w_grant      = (r_state == S_IDLE) & w_any_req;
    assign w_force_imem = (r_burst_cnt == c_CNT_W'(MAX_DATA_BURST));

    // Counts data grants that were issued while fetch was also waiting.
    // Any fetch grant, or a data grant with fetch idle, clears it. It can
    // never pass the limit: at the limit a contested slot goes to fetch.
    always_comb begin
        w_burst_cnt_nxt = r_burst_cnt;
        if (w_grant) begin
            if (!w_pick_d) begin
                w_burst_cnt_nxt = '0;
            end else if (i_imem_req) begin
                w_burst_cnt_nxt = r_burst_cnt + c_CNT_W'(1);
            end else begin
                w_burst_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end
`else
    // Strict data priority: fetch is never pushed ahead of data. The burst
    // limit has no role in this build; the term below is constant zero and
    // only keeps the parameter referenced.
    assign w_force_imem = 1'b0 & (MAX_DATA_BURST != 0);
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_wmask_nxt  = r_mem_wmask;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_owner_d_nxt    = r_owner_d;
        w_imem_rdata_nxt = r_imem_rdata;
        w_dmem_rdata_nxt = r_dmem_rdata;
        // Acks are pulses: only the WAIT->RESP transition raises one.
        w_imem_ack_nxt   = 1'b0;
        w_dmem_ack_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    // Fields are captured here so later upstream changes
                    // cannot disturb the in-flight transaction.
                    w_owner_d_nxt = w_pick_d;
                    w_mem_req_nxt = 1'b1;
                    if (w_pick_d) begin
                        w_mem_we_nxt    = i_dmem_we;
                        w_mem_wmask_nxt = i_dmem_wmask;
                        w_mem_addr_nxt  = i_dmem_addr;
                        w_mem_wdata_nxt = i_dmem_wdata;
                    end else begin
                        // Fetches are always plain reads.
                        w_mem_we_nxt    = 1'b0;
                        w_mem_wmask_nxt = '0;
                        w_mem_addr_nxt  = i_imem_addr;
                        w_mem_wdata_nxt = '0;
                    end
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (i_mem_gnt) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_mem_rvalid) begin
                    if (r_owner_d) begin
                        w_dmem_ack_nxt = 1'b1;
                        // A write's response carries no data worth keeping;
                        // the last read value stays visible.
                        if (!r_mem_we) begin
                            w_dmem_rdata_nxt = i_mem_rdata;
                        end
                    end else begin
                        w_imem_ack_nxt   = 1'b1;
                        w_imem_rdata_nxt = i_mem_rdata;
                    end
                    w_state_nxt = S_RESP;
                end
            end

            S_RESP: begin
                // Ack is high this cycle; requests are not looked at until
                // IDLE so the requester has a cycle to drop or renew.
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wmask  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_owner_d    <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_rdata <= '0;
            r_imem_ack   <= 1'b0;
            r_dmem_ack   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wmask  <= w_mem_wmask_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_owner_d    <= w_owner_d_nxt;
            r_imem_rdata <= w_imem_rdata_nxt;
            r_dmem_rdata <= w_dmem_rdata_nxt;
            r_imem_ack   <= w_imem_ack_nxt;
            r_dmem_ack   <= w_dmem_ack_nxt;
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_wmask  = r_mem_wmask;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_imem_rdata = r_imem_rdata;
    assign o_imem_ack   = r_imem_ack;
    assign o_dmem_rdata = r_dmem_rdata;
    assign o_dmem_ack   = r_dmem_ack;

endmodule

`default_nettype wire
